ahb_ssram_init_master: RTL and testbench
========================================

AHB_SSRAM_INIT_MASTER -- requirements
Module: ahb_ssram_init_master

Interface
REQ-001 SHALL have parameter AW, default 12, byte-address width of HADDR.
REQ-002 SHALL have: HCLK  in  1  clock; all flops on rising edge.
REQ-003 SHALL have: HRESET  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have: start  in  1  one-cycle request to begin a run; ignored while busy=1.
REQ-005 SHALL have: base_addr  in  AW  first byte address; bits [1:0] treated as 0.
REQ-006 SHALL have: word_count  in  AW-1  number of 32-bit words to fill.
REQ-007 SHALL have: fill_data  in  32  fill value.
REQ-008 SHALL have: incr_mode  in  1  0 = constant fill; 1 = fill_data + word index (mod 2^32).
REQ-009 SHALL have: verify_en  in  1  1 = read back and compare after the fill.
REQ-010 SHALL have: busy  out  1 (run in progress), done  out  1 (one-cycle end pulse), error  out  1 (sticky until next accepted start), err_addr  out  AW (address of first failure).
REQ-011 SHALL have AHB master ports: HADDR out AW, HTRANS out 2, HSIZE out 3, HWRITE out 1, HWDATA out 32, HRDATA in 32, HREADY in 1, HRESP in 1.

Function
REQ-012 SHALL sample base_addr, word_count, fill_data, incr_mode and verify_en on the accepted start; later changes SHALL NOT affect the run.
REQ-013 SHALL implement states IDLE, WR, WR_LAST, RD, RD_LAST, DONE.
REQ-014 SHALL, in IDLE on start with word_count=0, go to DONE: no AHB transfer, done pulses next cycle.
REQ-015 SHALL, in IDLE on start with word_count>0, go to WR and assert busy from the next cycle until DONE is left.
REQ-016 SHALL drive HTRANS=NONSEQ on every transfer (no bursts), HSIZE=3'b010, and HTRANS=IDLE (2'b00) in all other states.
REQ-017 SHALL form word i's address as base_addr + 4*i, wrapping modulo 2^AW.
REQ-018 SHALL hold HADDR/HTRANS/HWRITE stable while HREADY=0 and advance only on a cycle with HREADY=1.
REQ-019 SHALL drive HWDATA for word i in its data phase (the cycle after address acceptance) and hold it until HREADY=1; value = fill_data, or fill_data+i when incr_mode=1.
REQ-020 SHALL overlap the address of word i+1 with the data phase of word i (full pipelining, one word per cycle at HREADY=1).
REQ-021 SHALL, in WR, move to WR_LAST when the last write address is accepted; WR_LAST drives HTRANS=IDLE and waits for the final data phase (HREADY=1).
REQ-022 SHALL, on leaving WR_LAST, go to RD (index reset to 0) if verify_en=1, else to DONE.
REQ-023 SHALL, in RD/RD_LAST, issue reads (HWRITE=0) pipelined as in REQ-020, and capture HRDATA in each data phase ending with HREADY=1.
REQ-024 SHALL compare each read word with its REQ-019 value; on first mismatch set error and load err_addr; later mismatches SHALL NOT change err_addr.
REQ-025 SHALL tolerate the slave stalling a read issued right after a write (HREADY=0 for one or more cycles) with no data loss.
REQ-026 SHALL, on HRESP=1 with HREADY=0 (first error cycle), drive HTRANS=IDLE next cycle, set error, load err_addr (if not already set) with the failing transfer address, and go to DONE after HREADY=1.
REQ-027 SHALL, in DONE, pulse done=1 for exactly one cycle, deassert busy, and return to IDLE.
REQ-028 SHALL clear error and err_addr on each accepted start.
REQ-029 SHALL have total latency with HREADY always 1 of: 1 (start) + N + 1 cycles for write, + N + 1 if verify, + 1 DONE cycle.

Reset
REQ-030 SHALL, while HRESET=1, force state=IDLE, HTRANS=2'b00, HADDR=0, HWRITE=0, HSIZE=3'b010, HWDATA=0, busy=0, done=0, error=0, err_addr=0, counters=0, asynchronously.
REQ-031 SHALL, on reset asserted mid-run, abort immediately with no further transfers; the next start after release runs normally.

Verification
REQ-032 base=0x100, count=4, fill=0xA5A5A5A5, incr=0, verify=0, HREADY=1 -> writes at 0x100,0x104,0x108,0x10C on consecutive cycles; done 7 cycles after start; error=0.
REQ-033 base=0x000, count=3, fill=0x10, incr=1, verify=1, slave inserts 1 wait on first read -> HWDATA 0x10,0x11,0x12; reads 0x0,0x4,0x8; error=0.
REQ-034 Same as REQ-033 but slave returns 0xDEAD at 0x4 and 0x8 -> error=1, err_addr=0x4 after done.
REQ-035 AW=12, base=0xFF8, count=4 -> addresses 0xFF8,0xFFC,0x000,0x004.
REQ-036 count=0 -> no NONSEQ ever driven; done pulses 1 cycle after start; start during busy ignored.
REQ-037 HRESP error on 2nd write, and HRESET asserted mid-fill -> first: HTRANS IDLE next cycle, error=1, err_addr=base+4, done; second: outputs at reset values same cycle.

Source files
------------

// File: rtl/ahb_ssram_init_master.sv
// AHB-Lite master that fills an SSRAM region with a constant or incrementing
// word pattern, optionally reading it back and flagging the first bad address.
module ahb_ssram_init_master #(
    parameter int AW = 12
) (
    input  logic          HCLK,
    input  logic          HRESET,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [AW-2:0] word_count,
    input  logic [31:0]   fill_data,
    input  logic          incr_mode,
    input  logic          verify_en,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic [AW-1:0] err_addr,
    output logic [AW-1:0] HADDR,
    output logic [1:0]    HTRANS,
    output logic [2:0]    HSIZE,
    output logic          HWRITE,
    output logic [31:0]   HWDATA,
    input  logic [31:0]   HRDATA,
    input  logic          HREADY,
    input  logic          HRESP
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_WR_LAST,
        S_RD,
        S_RD_LAST,
        S_DONE
    } state_t;

    localparam logic [1:0]    HTRANS_IDLE   = 2'b00;
    localparam logic [1:0]    HTRANS_NONSEQ = 2'b10;
    localparam logic [AW-1:0] BASE_MASK     = {{(AW-2){1'b1}}, 2'b00};
    localparam logic [AW-2:0] IDX_ONE       = {{(AW-2){1'b0}}, 1'b1};

    state_t        state_q;
    logic [AW-1:0] base_q;
    logic [AW-2:0] cnt_q;
    logic [31:0]   fill_q;
    logic          incr_q;
    logic          verify_q;
    logic [AW-2:0] idx_q;       // word currently in address phase
    logic [AW-2:0] dp_idx_q;    // word currently in data phase
    logic [AW-1:0] dp_addr_q;
    logic          dp_vld_q;
    logic          dp_wr_q;
    logic          abort_q;
    logic [AW-1:0] haddr_q;
    logic [1:0]    htrans_q;
    logic          hwrite_q;
    logic [31:0]   hwdata_q;
    logic          busy_q;
    logic          done_q;
    logic          error_q;
    logic [AW-1:0] err_addr_q;

    logic [AW-2:0] idx_d;
    logic [AW-1:0] haddr_d;
    logic [31:0]   wdata_d;
    logic [31:0]   rexp_d;
    logic          last_d;
    logic          resp_err_d;
    logic          err_set_d;

    function automatic logic [AW-1:0] word_addr(input logic [AW-1:0] base,
                                                input logic [AW-2:0] idx);
        logic [AW:0] off;
        off = {idx, 2'b00};
        return base + off[AW-1:0];
    endfunction

    function automatic logic [31:0] word_val(input logic [31:0]   fill,
                                             input logic          incr,
                                             input logic [AW-2:0] idx);
        return incr ? fill + 32'(idx) : fill;
    endfunction

    always_comb begin
        idx_d      = idx_q + IDX_ONE;
        haddr_d    = word_addr(base_q, idx_d);
        wdata_d    = word_val(fill_q, incr_q, idx_q);
        rexp_d     = word_val(fill_q, incr_q, dp_idx_q);
        last_d     = (idx_d == cnt_q);
        resp_err_d = dp_vld_q && HRESP && !HREADY;
        err_set_d  = 1'b0;
        if (resp_err_d) begin
            err_set_d = 1'b1;
        end else if (dp_vld_q && !dp_wr_q && !abort_q && HREADY && (HRDATA != rexp_d)) begin
            err_set_d = 1'b1;
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q    <= S_IDLE;
            base_q     <= '0;
            cnt_q      <= '0;
            fill_q     <= '0;
            incr_q     <= 1'b0;
            verify_q   <= 1'b0;
            idx_q      <= '0;
            dp_idx_q   <= '0;
            dp_addr_q  <= '0;
            dp_vld_q   <= 1'b0;
            dp_wr_q    <= 1'b0;
            abort_q    <= 1'b0;
            haddr_q    <= '0;
            htrans_q   <= HTRANS_IDLE;
            hwrite_q   <= 1'b0;
            hwdata_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            err_addr_q <= '0;
        end else begin
            done_q <= 1'b0;
            // err_addr latches only the first failure of a run
            if (err_set_d) begin
                error_q <= 1'b1;
                if (!error_q) err_addr_q <= dp_addr_q;
            end
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        base_q     <= base_addr & BASE_MASK;
                        cnt_q      <= word_count;
                        fill_q     <= fill_data;
                        incr_q     <= incr_mode;
                        verify_q   <= verify_en;
                        idx_q      <= '0;
                        dp_vld_q   <= 1'b0;
                        abort_q    <= 1'b0;
                        error_q    <= 1'b0;
                        err_addr_q <= '0;
                        if (word_count == '0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q  <= S_WR;
                            busy_q   <= 1'b1;
                            haddr_q  <= base_addr & BASE_MASK;
                            htrans_q <= HTRANS_NONSEQ;
                            hwrite_q <= 1'b1;
                        end
                    end
                end
                S_WR, S_RD: begin
                    if (resp_err_d) begin
                        // cancel the pending address and drain the error response
                        htrans_q <= HTRANS_IDLE;
                        abort_q  <= 1'b1;
                        state_q  <= (state_q == S_WR) ? S_WR_LAST : S_RD_LAST;
                    end else if (HREADY) begin
                        dp_vld_q  <= 1'b1;
                        dp_wr_q   <= hwrite_q;
                        dp_idx_q  <= idx_q;
                        dp_addr_q <= haddr_q;
                        if (hwrite_q) hwdata_q <= wdata_d;
                        if (last_d) begin
                            htrans_q <= HTRANS_IDLE;
                            state_q  <= (state_q == S_WR) ? S_WR_LAST : S_RD_LAST;
                        end else begin
                            idx_q   <= idx_d;
                            haddr_q <= haddr_d;
                        end
                    end
                end
                S_WR_LAST, S_RD_LAST: begin
                    if (resp_err_d) begin
                        abort_q <= 1'b1;
                    end else if (HREADY) begin
                        dp_vld_q <= 1'b0;
                        if (state_q == S_WR_LAST && verify_q && !abort_q) begin
                            state_q  <= S_RD;
                            idx_q    <= '0;
                            haddr_q  <= base_q;
                            htrans_q <= HTRANS_NONSEQ;
                            hwrite_q <= 1'b0;
                        end else begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state_q  <= S_IDLE;
                    hwrite_q <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign HADDR    = haddr_q;
    assign HTRANS   = htrans_q;
    assign HSIZE    = 3'b010;
    assign HWRITE   = hwrite_q;
    assign HWDATA   = hwdata_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign error    = error_q;
    assign err_addr = err_addr_q;

endmodule

// File: tb/tb_ahb_ssram_init_master.sv
// Directed bench for ahb_ssram_init_master: a small AHB slave with memory,
// wait-state / error injection and a bus log, checked against fixed vectors.
module tb_ahb_ssram_init_master;
    localparam int AW = 12;

    logic          HCLK = 1'b0;
    logic          HRESET;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW-2:0] word_count;
    logic [31:0]   fill_data;
    logic          incr_mode;
    logic          verify_en;
    logic          busy;
    logic          done;
    logic          error;
    logic [AW-1:0] err_addr;
    logic [AW-1:0] HADDR;
    logic [1:0]    HTRANS;
    logic [2:0]    HSIZE;
    logic          HWRITE;
    logic [31:0]   HWDATA;
    logic [31:0]   HRDATA = '0;
    logic          HREADY = 1'b1;
    logic          HRESP  = 1'b0;

    ahb_ssram_init_master #(.AW(AW)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .start(start), .base_addr(base_addr),
        .word_count(word_count), .fill_data(fill_data), .incr_mode(incr_mode),
        .verify_en(verify_en), .busy(busy), .done(done), .error(error),
        .err_addr(err_addr), .HADDR(HADDR), .HTRANS(HTRANS), .HSIZE(HSIZE),
        .HWRITE(HWRITE), .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY),
        .HRESP(HRESP)
    );

    always #5 HCLK = ~HCLK;

    int n_chk = 0;
    int n_bad = 0;
    int done_cyc;

    // slave knobs and bus log
    logic [31:0] mem [0:1023];
    int          wait_wr_k, wait_rd_k, err_wr_k;
    logic        bad_en;
    logic [31:0] waddr_log[$];
    logic [31:0] raddr_log[$];
    logic [31:0] wdata_log[$];
    int          wr_n, rd_n, done_cnt, busy_cnt, nonseq_cnt, stab_bad;
    logic [1:0]  htrans_after_err;

    logic          dp_pend = 1'b0, dp_write = 1'b0;
    logic [AW-1:0] dp_addr = '0;
    int            wait_left = 0, err_left = 0;
    logic          prev_stall = 1'b0, prev_wstall = 1'b0, prev_err1 = 1'b0;
    logic [AW-1:0] p_addr;
    logic [1:0]    p_trans;
    logic          p_write;
    logic [31:0]   p_wdata;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_list(input string tag, input logic [31:0] got[$],
                            input logic [31:0] e[4], input int n);
        chk({tag, "_len"}, 32'(got.size()), 32'(n));
        for (int i = 0; i < n; i++)
            chk($sformatf("%s[%0d]", tag, i), (i < got.size()) ? got[i] : 32'hxxxxxxxx, e[i]);
    endtask

    always @(negedge HCLK) begin
        if (HRESET) begin
            dp_pend = 1'b0; wait_left = 0; err_left = 0;
            HREADY = 1'b1; HRESP = 1'b0;
            prev_stall = 1'b0; prev_wstall = 1'b0; prev_err1 = 1'b0;
        end else begin
            if (prev_stall && (HADDR !== p_addr || HTRANS !== p_trans || HWRITE !== p_write))
                stab_bad++;
            if (prev_wstall && HWDATA !== p_wdata) stab_bad++;
            if (prev_err1) htrans_after_err = HTRANS;
            if (HTRANS == 2'b10) nonseq_cnt++;
            if (busy) busy_cnt++;
            if (done) done_cnt++;
            HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0;
            if (dp_pend) begin
                if (err_left == 2) begin
                    HREADY = 1'b0; HRESP = 1'b1; err_left = 1;
                end else if (err_left == 1) begin
                    HRESP = 1'b1; err_left = 0;
                end else if (wait_left > 0) begin
                    HREADY = 1'b0; wait_left--;
                end
            end
            prev_stall  = (HTRANS == 2'b10) && !HREADY && !HRESP;
            prev_wstall = dp_pend && dp_write && !HREADY;
            prev_err1   = HRESP && !HREADY;
            p_addr = HADDR; p_trans = HTRANS; p_write = HWRITE; p_wdata = HWDATA;
            if (dp_pend && HREADY) begin
                if (dp_write) begin
                    if (!HRESP) begin
                        mem[dp_addr[AW-1:2]] = HWDATA;
                        wdata_log.push_back(HWDATA);
                    end
                end else begin
                    HRDATA = (bad_en && (dp_addr == 12'h004 || dp_addr == 12'h008)) ?
                             32'h0000DEAD : mem[dp_addr[AW-1:2]];
                end
                dp_pend = 1'b0;
            end
            if (HTRANS == 2'b10 && HREADY) begin
                dp_pend = 1'b1; dp_write = HWRITE; dp_addr = HADDR;
                wait_left = 0; err_left = 0;
                if (HWRITE) begin
                    waddr_log.push_back(32'(HADDR));
                    if (wr_n == wait_wr_k) wait_left = 2;
                    if (wr_n == err_wr_k) err_left = 2;
                    wr_n++;
                end else begin
                    raddr_log.push_back(32'(HADDR));
                    if (rd_n == wait_rd_k) wait_left = 1;
                    rd_n++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic knobs(input int wwk, input int wrk, input int ewk, input logic bad);
        wait_wr_k = wwk; wait_rd_k = wrk; err_wr_k = ewk; bad_en = bad;
    endtask

    task automatic clear_logs();
        waddr_log.delete(); raddr_log.delete(); wdata_log.delete();
        wr_n = 0; rd_n = 0; done_cnt = 0; busy_cnt = 0; nonseq_cnt = 0; stab_bad = 0;
        htrans_after_err = 2'b11;
    endtask

    // done_cyc = cycle in which done is seen, with the start cycle as cycle 0
    task automatic run(input logic [AW-1:0] b, input int n, input logic [31:0] f,
                       input logic inc, input logic ver, input int bump);
        clear_logs();
        base_addr = b; word_count = n[AW-2:0]; fill_data = f;
        incr_mode = inc; verify_en = ver; start = 1'b1;
        tick();
        start = 1'b0;
        base_addr = 12'hABC; word_count = 11'd9; fill_data = 32'h5555_0000;
        incr_mode = ~inc; verify_en = ~ver;
        done_cyc = -1;
        for (int k = 1; k < 300 && done_cyc < 0; k++) begin
            if (done === 1'b1) done_cyc = k;
            else begin
                start = (k == bump);
                tick();
            end
        end
        start = 1'b0;
        if (done_cyc < 0) chk("run_timeout", 32'd0, 32'd1);
        repeat (3) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        HRESET = 1'b1; start = 1'b0; base_addr = '0; word_count = '0;
        fill_data = '0; incr_mode = 1'b0; verify_en = 1'b0;
        knobs(-1, -1, -1, 1'b0);
        clear_logs();
        repeat (3) tick();
        chk("rst_htrans", 32'(HTRANS), 32'd0);
        chk("rst_haddr", 32'(HADDR), 32'd0);
        chk("rst_hsize", 32'(HSIZE), 32'd2);
        chk("rst_busy_done_err", {busy, done, error}, 32'd0);
        chk("rst_err_addr", 32'(err_addr), 32'd0);
        HRESET = 1'b0;
        tick();

        // constant fill, no verify, start re-requested while busy
        run(12'h100, 4, 32'hA5A5A5A5, 1'b0, 1'b0, 2);
        chk("t1_done_cyc", 32'(done_cyc), 32'd6);
        chk_list("t1_waddr", waddr_log, '{32'h100, 32'h104, 32'h108, 32'h10C}, 4);
        chk_list("t1_wdata", wdata_log, '{32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5}, 4);
        chk("t1_reads", 32'(raddr_log.size()), 32'd0);
        chk("t1_error", 32'(error), 32'd0);
        chk("t1_done_pulses", 32'(done_cnt), 32'd1);
        chk("t1_busy_cycles", 32'(busy_cnt), 32'd5);
        chk("t1_htrans_end", 32'(HTRANS), 32'd0);

        // incrementing fill with verify, one wait on the first read
        knobs(-1, 0, -1, 1'b0);
        run(12'h000, 3, 32'h10, 1'b1, 1'b1, 0);
        chk("t2_done_cyc", 32'(done_cyc), 32'd10);
        chk_list("t2_wdata", wdata_log, '{32'h10, 32'h11, 32'h12, 32'h0}, 3);
        chk_list("t2_raddr", raddr_log, '{32'h0, 32'h4, 32'h8, 32'h0}, 3);
        chk("t2_error", 32'(error), 32'd0);
        chk("t2_stable", 32'(stab_bad), 32'd0);

        // readback corrupted at 0x4 and 0x8: first failure wins
        knobs(-1, 0, -1, 1'b1);
        run(12'h000, 3, 32'h10, 1'b1, 1'b1, 0);
        chk("t3_error", 32'(error), 32'd1);
        chk("t3_err_addr", 32'(err_addr), 32'h4);
        chk("t3_done_cyc", 32'(done_cyc), 32'd10);

        // address wrap at top of space, 32-bit data wrap, 2-cycle write stall
        knobs(1, -1, -1, 1'b0);
        run(12'hFF8, 4, 32'hFFFFFFFE, 1'b1, 1'b1, 0);
        chk_list("t4_waddr", waddr_log, '{32'hFF8, 32'hFFC, 32'h000, 32'h004}, 4);
        chk_list("t4_wdata", wdata_log, '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h0, 32'h1}, 4);
        chk_list("t4_raddr", raddr_log, '{32'hFF8, 32'hFFC, 32'h000, 32'h004}, 4);
        chk("t4_error", 32'(error), 32'd0);
        chk("t4_stable", 32'(stab_bad), 32'd0);
        chk("t4_done_cyc", 32'(done_cyc), 32'd13);

        // zero-length run
        knobs(-1, -1, -1, 1'b0);
        run(12'h040, 0, 32'h1, 1'b0, 1'b1, 0);
        chk("t5_done_cyc", 32'(done_cyc), 32'd1);
        chk("t5_nonseq", 32'(nonseq_cnt), 32'd0);
        chk("t5_busy_cycles", 32'(busy_cnt), 32'd0);
        chk("t5_done_pulses", 32'(done_cnt), 32'd1);

        // error response on the second write
        knobs(-1, -1, 1, 1'b0);
        run(12'h100, 4, 32'h77, 1'b0, 1'b1, 0);
        chk("t6_htrans_after_err", 32'(htrans_after_err), 32'd0);
        chk("t6_error", 32'(error), 32'd1);
        chk("t6_err_addr", 32'(err_addr), 32'h104);
        chk("t6_done_cyc", 32'(done_cyc), 32'd5);
        chk("t6_waddr_len", 32'(waddr_log.size()), 32'd2);
        chk("t6_reads", 32'(raddr_log.size()), 32'd0);

        // next accepted start clears the sticky error
        knobs(-1, -1, -1, 1'b0);
        run(12'h300, 2, 32'h1234, 1'b0, 1'b0, 0);
        chk("t7_error_cleared", 32'(error), 32'd0);
        chk("t7_err_addr_cleared", 32'(err_addr), 32'd0);

        // asynchronous reset in the middle of a fill
        clear_logs();
        base_addr = 12'h020; word_count = 11'd8; fill_data = 32'h0F0F0F0F;
        incr_mode = 1'b0; verify_en = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        chk("t8_busy_before", 32'(busy), 32'd1);
        #2 HRESET = 1'b1;
        #1;
        chk("t8_rst_htrans", 32'(HTRANS), 32'd0);
        chk("t8_rst_haddr", 32'(HADDR), 32'd0);
        chk("t8_rst_hwdata", HWDATA, 32'd0);
        chk("t8_rst_busy", 32'(busy), 32'd0);
        chk("t8_rst_hwrite", 32'(HWRITE), 32'd0);
        tick(); tick();
        HRESET = 1'b0;
        repeat (3) tick();
        chk("t8_no_more_xfers", 32'(waddr_log.size()), 32'd2);
        run(12'h040, 2, 32'hCAFE, 1'b0, 1'b0, 0);
        chk_list("t8_waddr", waddr_log, '{32'h040, 32'h044, 32'h0, 32'h0}, 2);
        chk("t8_done_cyc", 32'(done_cyc), 32'd4);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
